nios2_debug_scan_host: RTL and testbench
========================================

# nios2_debug_scan_host

Clock-domain-local scan initiator that drives the virtual-JTAG side of the Nios II debug slave from fabric logic instead of the SLD hub. It accepts one command at a time: a 2-bit IR, and optionally a 38-bit DR payload. It then emits the UIR → CDR → SDR×38 → E1DR virtual-state sequence on a divided TCK, captures TDO into a 38-bit response, and returns to Run-Test/Idle. It sits in Computer_System in place of the hub, driving the debug slave's tck/tdi/ir_in/vs_* inputs, for scripted on-chip debug and regression.

## Interface
Parameters:
- DR_WIDTH, 38, scan-chain length in bits.
- IR_WIDTH, 2, virtual IR width.
- TCK_DIV, 2, clk cycles per TCK half-period; legal values ≥1.

Ports:
- clk  in  1  system clock; all logic is synchronous to it. One clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when a command can be accepted.
- cmd_ir  in  IR_WIDTH  IR value to load.
- cmd_ir_only  in  1  1 = perform the UIR step only; skip the DR scan.
- cmd_dr  in  DR_WIDTH  DR shift-in data, shifted LSB first.
- rsp_valid  out  1  one-clk pulse at command completion.
- rsp_dr  out  DR_WIDTH  captured TDO bits; bit i is the i-th bit shifted out.
- rsp_ir  out  IR_WIDTH  ir_out sampled during UIR.
- tck  out  1  divided scan clock.
- tdi  out  1  scan data to the slave.
- tdo  in  1  scan data from the slave.
- ir_in  out  IR_WIDTH  virtual IR.
- ir_out  in  IR_WIDTH  slave IR status.
- vs_uir, vs_cdr, vs_sdr, vs_e1dr  out  1 each  virtual-state indicators.
- jtag_state_rti  out  1  Run-Test/Idle indicator.

## Operation
States: IDLE, UIR, CDR, SDR, E1DR. Each non-IDLE state lasts whole TCK periods.
- IDLE:
  - Outputs: tck=0, jtag_state_rti=1, all vs_*=0, tdi=0, cmd_ready=1.
  - On cmd_valid & cmd_ready: latch cmd_ir into ir_in, cmd_dr into the shift register, and cmd_ir_only. Go to UIR.
- UIR: 1 TCK period, vs_uir=1.
  - Sample ir_out into rsp_ir on the TCK rising edge.
  - At the falling edge: if ir_only, go to IDLE and pulse rsp_valid with rsp_dr=0. Otherwise go to CDR.
- CDR: 1 TCK period, vs_cdr=1.
  - At the falling edge: go to SDR and drive tdi=shift[0].
- SDR: DR_WIDTH TCK periods, vs_sdr=1, bit counter 0..DR_WIDTH-1.
  - On each rising edge, sample tdo into capture[count].
  - On each falling edge: shift right, tdi=next bit, count+1.
  - After the falling edge at count=DR_WIDTH-1, go to E1DR with tdi=0.
- E1DR: 1 TCK period, vs_e1dr=1.
  - At the falling edge: go to IDLE, rsp_dr←capture, pulse rsp_valid.
- ir_in holds its last value until the next command is accepted.
- rsp_dr and rsp_ir hold until the next completion.
- cmd_ready=0 in every state other than IDLE. cmd_valid while busy is ignored; no queuing.

## Timing
- TCK generation: a phase counter runs 0..2·TCK_DIV−1 while not IDLE.
  - tck goes 1 at count TCK_DIV and 0 at wrap.
  - All output changes (state, vs_*, tdi) occur on the clk edge that drives tck 1→0, or on the accept edge.
  - tdo/ir_out are sampled on the same clk edge that drives tck 0→1, i.e. they are pre-shift values.
- Let P = 2·TCK_DIV. With accept at edge k:
  - Full scan: rsp_valid rises at edge k + (DR_WIDTH+3)·P. Default: k+164.
  - IR-only: rsp_valid rises at edge k + P.
- Back-to-back: cmd_ready is high in the rsp_valid cycle. A command accepted then starts UIR at the next edge; minimum 1 clk of rti=1 between commands.
- Reset values: tck=0, tdi=0, ir_in=0, all vs_*=0, jtag_state_rti=1, cmd_ready=1, rsp_valid=0, rsp_dr=0, rsp_ir=0, state IDLE.
- reset_n low mid-scan: all outputs take reset values immediately (asynchronous). No rsp_valid is issued; the partial capture is discarded.
- The tck duty cycle is exactly 50%. No tck glitch at entry to or exit from IDLE.

## Test plan
- Reset then idle: hold reset_n low 5 clks, release → tck=0, rti=1, cmd_ready=1, all vs_*=0 for 20 clks.
- IR-only: cmd_ir=2'b10, ir_only=1, ir_out=2'b01 → ir_in=2, vs_uir high 4 clks, rsp_valid at k+4, rsp_ir=1, rsp_dr=0.
- Loopback full scan: tdo driven by a 38-bit behavioral shift register preloaded 38'h2A_DEAD_BEEF, cmd_dr=38'h15_1234_5678 → rsp_valid at k+164, rsp_dr=38'h2A_DEADBEEF, model register=38'h15_12345678, exactly 38 tck rises with vs_sdr=1.
- Back-to-back: hold cmd_valid high with two commands → second accepted in the first rsp_valid cycle, rti=1 for exactly 1 clk, second rsp_valid 165 clks after the first.
- Reset mid-SDR at bit 17 → outputs at reset values in the same cycle, no rsp_valid, next command completes normally with correct data.
- TCK_DIV=1: repeat loopback → rsp_valid at k+82, data identical.

Source files
------------

// File: rtl/nios2_debug_scan_host_if.sv
// Command/response and virtual-JTAG signal bundle between a scan host and its environment.
// master = scan host view, slave = environment (command source + debug slave) view.
interface nios2_debug_scan_host_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic                cmd_ir_only;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir;
  logic                tck;
  logic                tdi;
  logic                tdo;
  logic [IR_WIDTH-1:0] ir_in;
  logic [IR_WIDTH-1:0] ir_out;
  logic                vs_uir;
  logic                vs_cdr;
  logic                vs_sdr;
  logic                vs_e1dr;
  logic                jtag_state_rti;

  modport master (
    input  cmd_valid, cmd_ir, cmd_ir_only, cmd_dr, tdo, ir_out,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir, tck, tdi, ir_in,
           vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_ir_only, cmd_dr, tdo, ir_out,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir, tck, tdi, ir_in,
           vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti
  );
endinterface

// File: rtl/nios2_debug_scan_host.sv
// Virtual-JTAG scan initiator: UIR -> CDR -> SDR x DR_WIDTH -> E1DR on a divided TCK; rsp after (DR_WIDTH+3)*2*TCK_DIV clks, 2*TCK_DIV for IR-only.
// One command in flight: cmd_ready is high only in IDLE, commands offered while busy are not taken.
module nios2_debug_scan_host #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nios2_debug_scan_host_if.master bus
);

  localparam int PH_W  = (2 * TCK_DIV > 2) ? $clog2(2 * TCK_DIV) : 1;
  localparam int CNT_W = (DR_WIDTH > 2) ? $clog2(DR_WIDTH) : 1;
  localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(TCK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * TCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_E1DR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PH_W-1:0]     r_ph;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_tck;
  logic                r_tdi;
  logic [IR_WIDTH-1:0] r_ir_in;
  logic                r_ir_only;
  logic [DR_WIDTH-1:0] r_shift;
  logic [DR_WIDTH-1:0] r_cap;
  logic [IR_WIDTH-1:0] r_ir_cap;
  logic                r_rsp_vld;
  logic [DR_WIDTH-1:0] r_rsp_dr;
  logic [IR_WIDTH-1:0] r_rsp_ir;

  logic                w_busy;
  logic                w_accept;
  logic                w_rise;
  logic                w_fall;
  logic                w_cnt_last;
  logic                w_done;
  logic                w_idle;
  logic                w_uir;
  logic                w_cdr;
  logic                w_sdr;
  logic                w_e1dr;
  logic [DR_WIDTH-1:0] w_shift_nxt;

  // Rise/fall events are the clk edges that drive tck 0->1 and 1->0.
  assign w_busy      = (r_state != S_IDLE);
  assign w_accept    = bus.cmd_valid && (r_state == S_IDLE);
  assign w_rise      = w_busy && (r_ph == PH_RISE);
  assign w_fall      = w_busy && (r_ph == PH_LAST);
  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_shift_nxt = r_shift >> 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_idle      = 1'b0;
    w_uir       = 1'b0;
    w_cdr       = 1'b0;
    w_sdr       = 1'b0;
    w_e1dr      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_idle = 1'b1;
        if (bus.cmd_valid) w_state_nxt = S_UIR;
      end
      S_UIR: begin
        w_uir = 1'b1;
        if (w_fall) begin
          w_state_nxt = r_ir_only ? S_IDLE : S_CDR;
          w_done      = r_ir_only;
        end
      end
      S_CDR: begin
        w_cdr = 1'b1;
        if (w_fall) w_state_nxt = S_SDR;
      end
      S_SDR: begin
        w_sdr = 1'b1;
        if (w_fall && w_cnt_last) w_state_nxt = S_E1DR;
      end
      S_E1DR: begin
        w_e1dr = 1'b1;
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ph      <= '0;
      r_cnt     <= '0;
      r_tck     <= 1'b0;
      r_tdi     <= 1'b0;
      r_ir_in   <= '0;
      r_ir_only <= 1'b0;
      r_shift   <= '0;
      r_cap     <= '0;
      r_ir_cap  <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_dr  <= '0;
      r_rsp_ir  <= '0;
    end else begin
      r_rsp_vld <= 1'b0;
      if (w_accept) begin
        r_ir_in   <= bus.cmd_ir;
        r_shift   <= bus.cmd_dr;
        r_ir_only <= bus.cmd_ir_only;
        r_ph      <= '0;
        r_cnt     <= '0;
        r_tck     <= 1'b0;
        r_tdi     <= 1'b0;
      end else if (w_busy) begin
        r_ph <= w_fall ? '0 : r_ph + PH_W'(1);
        if (w_rise) begin
          r_tck <= 1'b1;
          if (r_state == S_UIR) r_ir_cap <= bus.ir_out;
          // Capture fills from the top so the first TDO bit ends at bit 0.
          if (r_state == S_SDR) r_cap <= {bus.tdo, r_cap[DR_WIDTH-1:1]};
        end
        if (w_fall) begin
          r_tck <= 1'b0;
          unique case (r_state)
            S_CDR: r_tdi <= r_shift[0];
            S_SDR: begin
              r_shift <= w_shift_nxt;
              r_cnt   <= r_cnt + CNT_W'(1);
              r_tdi   <= w_cnt_last ? 1'b0 : w_shift_nxt[0];
            end
            default: r_tdi <= 1'b0;
          endcase
        end
        if (w_done) begin
          r_rsp_vld <= 1'b1;
          r_rsp_ir  <= r_ir_cap;
          r_rsp_dr  <= (r_state == S_E1DR) ? r_cap : '0;
        end
      end
    end
  end

  assign bus.cmd_ready      = w_idle;
  assign bus.jtag_state_rti = w_idle;
  assign bus.vs_uir         = w_uir;
  assign bus.vs_cdr         = w_cdr;
  assign bus.vs_sdr         = w_sdr;
  assign bus.vs_e1dr        = w_e1dr;
  assign bus.tck            = r_tck;
  assign bus.tdi            = r_tdi;
  assign bus.ir_in          = r_ir_in;
  assign bus.rsp_valid      = r_rsp_vld;
  assign bus.rsp_dr         = r_rsp_dr;
  assign bus.rsp_ir         = r_rsp_ir;

endmodule

// File: tb/tb_nios2_debug_scan_host.sv
// Scoreboard bench: directed commands push expected responses; per-DUT monitors pop on rsp_valid.
// dut0 runs TCK_DIV=2, dut1 runs TCK_DIV=1; both see a behavioural loopback scan register.
module tb_nios2_debug_scan_host;
  localparam int DRW = 38;
  localparam int IRW = 2;

  typedef struct {
    logic [DRW-1:0] dr;
    logic [IRW-1:0] ir;
    int             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nios2_debug_scan_host_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) bus0();
  nios2_debug_scan_host_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) bus1();

  nios2_debug_scan_host #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0));
  nios2_debug_scan_host #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Loopback debug-slave models: shift on tck rise while in SDR, tdo is the LSB.
  logic [DRW-1:0] m0, m0_init, m1, m1_init;
  logic m0_ld = 1'b0;
  logic m1_ld = 1'b0;
  always @(posedge bus0.tck or posedge m0_ld)
    if (m0_ld) m0 <= m0_init;
    else if (bus0.vs_sdr) m0 <= {bus0.tdi, m0[DRW-1:1]};
  always @(posedge bus1.tck or posedge m1_ld)
    if (m1_ld) m1 <= m1_init;
    else if (bus1.vs_sdr) m1 <= {bus1.tdi, m1[DRW-1:1]};
  assign bus0.tdo = m0[0];
  assign bus1.tdo = m1[0];

  int sdr0 = 0;
  int sdr1 = 0;
  int uir0 = 0;
  int rti_cnt = 0;
  logic rti_en = 1'b0;
  always @(posedge bus0.tck) if (bus0.vs_sdr) sdr0 <= sdr0 + 1;
  always @(posedge bus1.tck) if (bus1.vs_sdr) sdr1 <= sdr1 + 1;
  always @(negedge clk) if (bus0.vs_uir) uir0 <= uir0 + 1;
  always @(negedge clk) if (rti_en && bus0.jtag_state_rti) rti_cnt <= rti_cnt + 1;

  always @(negedge clk) begin
    if (bus0.rsp_valid) begin
      if (q0.size() == 0) chk("dut0_unexpected_rsp", 64'd1, 64'd0);
      else begin
        e0 = q0.pop_front();
        chk("dut0_rsp_dr", 64'(bus0.rsp_dr), 64'(e0.dr));
        chk("dut0_rsp_ir", 64'(bus0.rsp_ir), 64'(e0.ir));
        chk("dut0_rsp_cycle", 64'(cyc), 64'(e0.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.rsp_valid) begin
      if (q1.size() == 0) chk("dut1_unexpected_rsp", 64'd1, 64'd0);
      else begin
        e1 = q1.pop_front();
        chk("dut1_rsp_dr", 64'(bus1.rsp_dr), 64'(e1.dr));
        chk("dut1_rsp_ir", 64'(bus1.rsp_ir), 64'(e1.ir));
        chk("dut1_rsp_cycle", 64'(cyc), 64'(e1.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge, cmd_valid left high.
  task automatic issue0(input logic [IRW-1:0] ir, input logic iro, input logic [DRW-1:0] dr,
                        input logic [DRW-1:0] edr, input logic [IRW-1:0] eir, input int lat,
                        output int acc);
    int n = 0;
    bus0.cmd_ir = ir;
    bus0.cmd_ir_only = iro;
    bus0.cmd_dr = dr;
    bus0.cmd_valid = 1'b1;
    while (!bus0.cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    if (!bus0.cmd_ready) chk("dut0_accept_timeout", 64'd0, 64'd1);
    else q0.push_back('{dr: edr, ir: eir, cyc: acc + lat});
    @(negedge clk);
  endtask

  task automatic issue1(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                        input logic [DRW-1:0] edr, input logic [IRW-1:0] eir, input int lat);
    int n = 0;
    bus1.cmd_ir = ir;
    bus1.cmd_ir_only = 1'b0;
    bus1.cmd_dr = dr;
    bus1.cmd_valid = 1'b1;
    while (!bus1.cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus1.cmd_ready) chk("dut1_accept_timeout", 64'd0, 64'd1);
    else q1.push_back('{dr: edr, ir: eir, cyc: cyc + 1 + lat});
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
  endtask

  task automatic wait_done0();
    int n = 0;
    while (q0.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0) begin
      chk("dut0_rsp_timeout", 64'(q0.size()), 64'd0);
      q0.delete();
    end
    @(negedge clk);
  endtask

  task automatic load0(input logic [DRW-1:0] v);
    m0_init = v;
    m0_ld = 1'b1;
    #1 m0_ld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int acc1, acc2, s, u, n;
    bus0.cmd_valid = 1'b0; bus0.cmd_ir = '0; bus0.cmd_ir_only = 1'b0; bus0.cmd_dr = '0;
    bus0.ir_out = 2'b01;
    bus1.cmd_valid = 1'b0; bus1.cmd_ir = '0; bus1.cmd_ir_only = 1'b0; bus1.cmd_dr = '0;
    bus1.ir_out = 2'b10;
    m1_init = '0;
    m1_ld = 1'b1;
    #1 m1_ld = 1'b0;
    load0('0);

    // Reset, then 20 idle clocks: {tck, rti, ready, vs_uir, vs_cdr, vs_sdr, vs_e1dr}
    repeat (5) @(negedge clk);
    chk("reset_outputs", 64'({bus0.tck, bus0.tdi, bus0.jtag_state_rti, bus0.cmd_ready, bus0.rsp_valid}),
        64'(5'b00110));
    chk("reset_rsp_ir_in", 64'({bus0.rsp_dr, bus0.rsp_ir, bus0.ir_in}), 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", 64'({bus0.tck, bus0.jtag_state_rti, bus0.cmd_ready, bus0.vs_uir,
                               bus0.vs_cdr, bus0.vs_sdr, bus0.vs_e1dr}), 64'(7'b0110000));
    end

    // IR-only: rsp after one TCK period (4 clks), rsp_ir=ir_out, rsp_dr=0
    u = uir0;
    issue0(2'b10, 1'b1, 38'h3F_FFFF_FFFF, 38'h0, 2'b01, 4, acc1);
    bus0.cmd_valid = 1'b0;
    chk("ir_only_ir_in", 64'(bus0.ir_in), 64'd2);
    wait_done0();
    chk("ir_only_vs_uir_clks", 64'(uir0 - u), 64'd4);

    // Loopback full scan
    load0(38'h2A_DEAD_BEEF);
    s = sdr0;
    issue0(2'b00, 1'b0, 38'h15_1234_5678, 38'h2A_DEAD_BEEF, 2'b01, 164, acc1);
    bus0.cmd_valid = 1'b0;
    wait_done0();
    chk("loopback_model", 64'(m0), 64'(38'h15_1234_5678));
    chk("loopback_sdr_rises", 64'(sdr0 - s), 64'd38);
    chk("loopback_end_idle", 64'({bus0.tck, bus0.tdi, bus0.jtag_state_rti}), 64'(3'b001));

    // Back-to-back with cmd_valid held high
    bus0.ir_out = 2'b11;
    load0(38'h00_FFFF_0000);
    issue0(2'b01, 1'b0, 38'h3F_0000_0001, 38'h00_FFFF_0000, 2'b11, 164, acc1);
    rti_en = 1'b1;
    issue0(2'b10, 1'b0, 38'h01_A5A5_5A5A, 38'h3F_0000_0001, 2'b11, 164, acc2);
    rti_en = 1'b0;
    bus0.cmd_valid = 1'b0;
    chk("b2b_accept_gap", 64'(acc2 - acc1), 64'd165);
    chk("b2b_ir_in", 64'(bus0.ir_in), 64'd2);
    wait_done0();
    chk("b2b_rti_clks", 64'(rti_cnt), 64'd1);
    chk("b2b_model", 64'(m0), 64'(38'h01_A5A5_5A5A));

    // Reset in the middle of SDR after 17 bits
    load0(38'h12_3456_789A);
    s = sdr0;
    issue0(2'b11, 1'b0, 38'h2B_CDEF_0123, 38'h12_3456_789A, 2'b11, 164, acc1);
    n = 0;
    while ((sdr0 - s) < 17 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("midscan_reach_bit17", 64'(sdr0 - s), 64'd17);
    #2;
    reset_n = 1'b0;
    bus0.cmd_valid = 1'b0;
    void'(q0.pop_back());
    #1;
    chk("midscan_reset_outputs",
        64'({bus0.tck, bus0.tdi, bus0.ir_in, bus0.vs_uir, bus0.vs_cdr, bus0.vs_sdr, bus0.vs_e1dr,
             bus0.jtag_state_rti, bus0.cmd_ready, bus0.rsp_valid}), 64'(11'b00000000110));
    chk("midscan_reset_rsp", 64'({bus0.rsp_dr, bus0.rsp_ir}), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    load0(38'h0A_5555_AAAA);
    issue0(2'b01, 1'b0, 38'h30_0F0F_F0F0, 38'h0A_5555_AAAA, 2'b11, 164, acc1);
    bus0.cmd_valid = 1'b0;
    wait_done0();
    chk("post_reset_model", 64'(m0), 64'(38'h30_0F0F_F0F0));

    // TCK_DIV=1 loopback on dut1
    m1_init = 38'h2A_DEAD_BEEF;
    m1_ld = 1'b1;
    #1 m1_ld = 1'b0;
    s = sdr1;
    issue1(2'b00, 38'h15_1234_5678, 38'h2A_DEAD_BEEF, 2'b10, 82);
    n = 0;
    while (q1.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("div1_rsp_seen", 64'(q1.size()), 64'd0);
    chk("div1_model", 64'(m1), 64'(38'h15_1234_5678));
    chk("div1_sdr_rises", 64'(sdr1 - s), 64'd38);

    repeat (10) @(negedge clk);
    chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
